// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared opcode, mux-select and state encodings for the multicycle MIPS control
package mips_defs;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // alu_op codes consumed by the funct decoder
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // alu_src_b selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // pc_src selects
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // State encodings; 13-15 are unused and fall back to FETCH
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd12;

    // Bundle of every control output driven toward the datapath
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM for the multicycle MIPS subset core
module mips_multicycle_ctrl
    import mips_defs::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       illegal_q;
    logic       was_illegal_q;
    ctrl_t      c;
    ctrl_t      c_out;

    // State register, sticky illegal flag, and entry tracking so a trapped ILLEGAL pulses instr_done once
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            illegal_q     <= 1'b0;
            was_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_q | (state_q == S_ILLEGAL);
            was_illegal_q <= (state_q == S_ILLEGAL);
        end
    end

    // Next-state and Moore output decode; enables that complete a memory access are qualified by mem_ready
    always_comb begin
        c            = '0;
        c.illegal_op = illegal_q;
        state_d      = S_FETCH;
        case (state_q)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_ALU;
                c.ir_write  = mem_ready;
                c.pc_en     = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_BRANCH;
                c.alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                state_d   = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req    = 1'b1;
                c.mem_write  = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = mem_ready;
                state_d      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_FUNCT;
                state_d     = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BEQEX: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_REG;
                c.alu_op     = ALU_SUB;
                c.pc_src     = PC_ALUOUT;
                c.pc_en      = zero;
                c.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JEX: begin
                c.pc_src     = PC_JUMP;
                c.pc_en      = 1'b1;
                c.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                c.illegal_op = 1'b1;
                c.instr_done = ~was_illegal_q;
                state_d      = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;
            end
            default: begin
                c.illegal_op = 1'b0;
            end
        endcase
    end

    // Reset forces every output low so an abandoned instruction cannot write anything
    always_comb begin
        c_out = reset ? '0 : c;
        state = reset ? 4'd0 : state_q;
    end

    assign mem_req    = c_out.mem_req;
    assign mem_write  = c_out.mem_write;
    assign iord       = c_out.iord;
    assign ir_write   = c_out.ir_write;
    assign reg_dst    = c_out.reg_dst;
    assign mem_to_reg = c_out.mem_to_reg;
    assign reg_write  = c_out.reg_write;
    assign alu_src_a  = c_out.alu_src_a;
    assign alu_src_b  = c_out.alu_src_b;
    assign alu_op     = c_out.alu_op;
    assign pc_src     = c_out.pc_src;
    assign pc_en      = c_out.pc_en;
    assign instr_done = c_out.instr_done;
    assign illegal_op = c_out.illegal_op;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS subset core (R-type, lw, sw, beq, addi, j).
- Sequences the shared datapath, one step per clock, by driving every 32-bit mux select, write enable and ALU-op code.
- Waits on a single-port memory through a req/ready handshake.
- Sits between the instruction register opcode field and the datapath; no datapath logic inside.

Parameters:
ILLEGAL_TRAP, 0, 1 = halt in ILLEGAL until reset; 0 = flag illegal opcode and resume fetch.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
mem_req  out  1  memory access request
mem_write  out  1  1 = write, 0 = read; valid with mem_req
iord  out  1  address mux: 0 = PC, 1 = ALUOut
ir_write  out  1  instruction register load
reg_dst  out  1  write-register mux: 0 = rt, 1 = rd
mem_to_reg  out  1  write-data mux: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC load enable
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_op  out  1  sticky illegal-opcode flag
state  out  4  current state, debug

Behaviour:
State encoding and register:
- 4-bit state register; encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, ILLEGAL=12.
- Encodings 13-15: all outputs 0, next state FETCH.

Reset:
- Reset sampled high: state <= FETCH, illegal_op <= 0.
- While reset is high, all outputs are forced to 0 (state output reads 0).
- First cycle after release is FETCH.
- Reset mid-instruction abandons it, with no write enable asserted on that cycle.

Output timing:
- Outputs are Moore-decoded from state. Exceptions: pc_en in BEQEX, and ir_write/pc_en/reg/mem enables gated by mem_ready, as listed below.
- Every output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_en=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - other -> ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD if opcode=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. instr_done=mem_ready. Wait for mem_ready, then FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10. Next RTYPEWB.
- RTYPEWB: reg_write=1, reg_dst=1, instr_done=1. Next FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, instr_done=1. Next FETCH.
- JEX: pc_src=10, pc_en=1, instr_done=1. Next FETCH.
- ILLEGAL: illegal_op set (sticky until reset), instr_done=1.
  - ILLEGAL_TRAP=0: next FETCH.
  - ILLEGAL_TRAP=1: remain in ILLEGAL; instr_done pulses only on entry.

Invariants and boundaries:
- opcode must stay stable from DECODE onward; it is sampled again in MEMADR.
- mem_ready is ignored in non-memory states.
- mem_req stays high across wait cycles with iord/mem_write held constant.
- Latency with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each wait cycle adds one.

Decomposition:
- Shared package/header mips_defs:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - ALU_OP codes
  - alu_src_b codes
  - pc_src codes
  - state encodings
- No sub-module: one sequential state register plus a combinational next-state/output block. The ALU funct decoder stays a separate existing block consuming alu_op.

Test Plan:
- Reset held 3 cycles with random inputs -> all outputs 0. Release -> FETCH (state=0), mem_req=1, iord=0.
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4. MEMWB has reg_write=1, mem_to_reg=1; instr_done on cycle 5 only; then back to FETCH.
- sw, with mem_ready low for 2 cycles in FETCH and 3 in MEMWR:
  - FETCH held with ir_write=0 and pc_en=0 until ready.
  - MEMWR holds mem_req=1, mem_write=1, iord=1.
  - Total 9 cycles; no reg_write at any point.
- beq with zero=1, then zero=0 -> BEQEX pc_en=1 then pc_en=0; pc_src=01, alu_op=01; 3 cycles each.
- R-type, addi, j back-to-back -> reg_dst=1 in RTYPEWB, 0 in ADDIWB; JEX pc_src=10, pc_en=1; totals 4, 4, 3 cycles.
- Illegal opcode 111111:
  - ILLEGAL_TRAP=0: illegal_op rises and stays 1, FETCH resumes.
  - ILLEGAL_TRAP=1: state stays 12 until reset; reset in MEMRD returns to FETCH with no writes.
